// File: rtl/instr_prefetch_queue_if.sv
// Prefetch-queue bus bundle: memory fetch port, redirect port and the CPU-facing
// instruction stream.
//   master : view used by the prefetch queue itself (drives mem_sel and instr_*).
//   slave  : view used by the memory/CPU side (drives mem_out, redirect*, instr_ready).
//   mem_sel/mem_out        : word fetch address and returned word (one edge later)
//   redirect/redirect_pc   : flush and restart fetching at redirect_pc
//   instr_out/instr_pc     : head instruction word and its byte address
//   instr_valid/instr_ready: head handshake
//   count                  : occupied queue entries
interface instr_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [31:0]     mem_sel;
    logic [31:0]     mem_out;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic [31:0]     instr_out;
    logic [31:0]     instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [CntW-1:0] count;

    modport master (
        output mem_sel,
        output instr_out,
        output instr_pc,
        output instr_valid,
        output count,
        input  mem_out,
        input  redirect,
        input  redirect_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_sel,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        input  count,
        output mem_out,
        output redirect,
        output redirect_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between instruction memory and the CPU.
// Issues sequential word fetches on mem_sel, captures each returned word one edge
// later into a DEPTH-entry FIFO, and presents {instr_out, instr_pc} with a
// valid/ready handshake. A redirect flushes the queue and the in-flight request.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : instr_prefetch_queue_if.master (memory, redirect and CPU signals)
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                    clock,
    input logic                    reset,
    instr_prefetch_queue_if.master bus
);
    localparam int unsigned   PtrW     = $clog2(DEPTH);
    localparam int unsigned   CntW     = PtrW + 1;
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            in_flight_q, in_flight_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];

    logic [CntW:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          valid;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^bus.redirect_pc[1:0];

    // Reserve a slot for the outstanding request so a push can never hit a full queue.
    assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, in_flight_q};
    assign issue     = !bus.redirect && (occupancy < DepthOcc);
    assign push      = in_flight_q && !bus.redirect;
    assign valid     = (count_q != '0);
    assign pop       = valid && bus.instr_ready && !bus.redirect;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        in_flight_d = 1'b0;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                in_flight_d = 1'b1;
                req_pc_d    = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + 32'd4;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            in_flight_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            in_flight_q <= in_flight_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Entries are cleared on reset so the head read is all-zero until the first push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (push) begin
            instr_mem_q[tail_q] <= bus.mem_out;
            pc_mem_q[tail_q]    <= req_pc_q;
        end
    end

    assign bus.mem_sel     = fetch_pc_q;
    assign bus.instr_out   = instr_mem_q[head_q];
    assign bus.instr_pc    = pc_mem_q[head_q];
    assign bus.instr_valid = valid;
    assign bus.count       = count_q;

    a_no_push_when_full: assert property (
        @(posedge clock) disable iff (reset) !(push && (count_q == DepthOcc[CntW-1:0]))
    );
endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;
    logic clock;
    logic reset;

    instr_prefetch_queue_if #(.DEPTH(4)) bus0 ();
    instr_prefetch_queue_if #(.DEPTH(4)) bus1 ();

    instr_prefetch_queue #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus0)
    );

    instr_prefetch_queue #(
        .DEPTH   (4),
        .RESET_PC(32'hFFFF_FFF8)
    ) u_dut_wrap (
        .clock(clock),
        .reset(reset),
        .bus  (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    // Instruction memory: samples mem_sel at the edge, word visible after it.
    always @(posedge clock) begin
        bus0.mem_out <= word_of(bus0.mem_sel);
        bus1.mem_out <= word_of(bus1.mem_sel);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic [31:0] e_sel;
    } vec_t;

    vec_t vecs [27];

    initial begin
        // rst redir rpc rdy | valid pc cnt mem_sel  (state after the edge)
        vecs[0]  = '{1, 0, 32'h0,   0, 0, 32'h0,   3'd0, 32'h0};
        // Streaming with ready high
        vecs[1]  = '{0, 0, 32'h0,   1, 0, 32'h0,   3'd0, 32'h4};
        vecs[2]  = '{0, 0, 32'h0,   1, 1, 32'h0,   3'd1, 32'h8};
        vecs[3]  = '{0, 0, 32'h0,   1, 1, 32'h4,   3'd1, 32'hC};
        vecs[4]  = '{0, 0, 32'h0,   1, 1, 32'h8,   3'd1, 32'h10};
        vecs[5]  = '{0, 0, 32'h0,   1, 1, 32'hC,   3'd1, 32'h14};
        // Fill with ready low, then drain
        vecs[6]  = '{1, 0, 32'h0,   0, 0, 32'h0,   3'd0, 32'h0};
        vecs[7]  = '{0, 0, 32'h0,   0, 0, 32'h0,   3'd0, 32'h4};
        vecs[8]  = '{0, 0, 32'h0,   0, 1, 32'h0,   3'd1, 32'h8};
        vecs[9]  = '{0, 0, 32'h0,   0, 1, 32'h0,   3'd2, 32'hC};
        vecs[10] = '{0, 0, 32'h0,   0, 1, 32'h0,   3'd3, 32'h10};
        vecs[11] = '{0, 0, 32'h0,   0, 1, 32'h0,   3'd4, 32'h10};
        vecs[12] = '{0, 0, 32'h0,   0, 1, 32'h0,   3'd4, 32'h10};
        vecs[13] = '{0, 0, 32'h0,   1, 1, 32'h4,   3'd3, 32'h10};
        vecs[14] = '{0, 0, 32'h0,   1, 1, 32'h8,   3'd2, 32'h14};
        vecs[15] = '{0, 0, 32'h0,   1, 1, 32'hC,   3'd2, 32'h18};
        vecs[16] = '{0, 0, 32'h0,   1, 1, 32'h10,  3'd2, 32'h1C};
        vecs[17] = '{0, 0, 32'h0,   1, 1, 32'h14,  3'd2, 32'h20};
        // count=3 with a request in flight, then redirect to unaligned 0x103
        vecs[18] = '{0, 0, 32'h0,   0, 1, 32'h14,  3'd3, 32'h24};
        vecs[19] = '{0, 1, 32'h103, 0, 0, 32'h0,   3'd0, 32'h100};
        vecs[20] = '{0, 0, 32'h0,   0, 0, 32'h0,   3'd0, 32'h104};
        vecs[21] = '{0, 0, 32'h0,   0, 1, 32'h100, 3'd1, 32'h108};
        // Redirect with ready high and a pending push, then back-to-back redirect
        vecs[22] = '{0, 1, 32'h200, 1, 0, 32'h0,   3'd0, 32'h200};
        vecs[23] = '{0, 1, 32'h300, 1, 0, 32'h0,   3'd0, 32'h300};
        vecs[24] = '{0, 0, 32'h0,   1, 0, 32'h0,   3'd0, 32'h304};
        vecs[25] = '{0, 0, 32'h0,   1, 1, 32'h300, 3'd1, 32'h308};
        vecs[26] = '{0, 0, 32'h0,   1, 1, 32'h304, 3'd1, 32'h30C};

        reset            = 1'b1;
        bus0.redirect    = 1'b0;
        bus0.redirect_pc = '0;
        bus0.instr_ready = 1'b0;
        bus1.redirect    = 1'b0;
        bus1.redirect_pc = '0;
        bus1.instr_ready = 1'b1;

        for (int i = 0; i < 27; i++) begin
            reset            = vecs[i].rst;
            bus0.redirect    = vecs[i].redir;
            bus0.redirect_pc = vecs[i].rpc;
            bus0.instr_ready = vecs[i].rdy;
            @(posedge clock);
            @(negedge clock);
            check($sformatf("v%0d valid", i), {31'd0, bus0.instr_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d count", i), {29'd0, bus0.count}, {29'd0, vecs[i].e_cnt});
            check($sformatf("v%0d mem_sel", i), bus0.mem_sel, vecs[i].e_sel);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d instr_pc", i), bus0.instr_pc, vecs[i].e_pc);
                check($sformatf("v%0d instr_out", i), bus0.instr_out, word_of(vecs[i].e_pc));
            end
            if (vecs[i].rst) begin
                check($sformatf("v%0d rst instr_pc", i), bus0.instr_pc, 32'h0);
                check($sformatf("v%0d rst instr_out", i), bus0.instr_out, 32'h0);
            end
        end

        // Asynchronous reset between edges with count=2
        bus0.redirect    = 1'b0;
        bus0.instr_ready = 1'b0;
        reset            = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("pre-async count", {29'd0, bus0.count}, 32'd2);
        reset = 1'b1;
        #1;
        check("async valid", {31'd0, bus0.instr_valid}, 32'd0);
        check("async count", {29'd0, bus0.count}, 32'd0);
        check("async instr_out", bus0.instr_out, 32'h0);
        check("async instr_pc", bus0.instr_pc, 32'h0);
        check("async mem_sel", bus0.mem_sel, 32'h0);
        check("async wrap mem_sel", bus1.mem_sel, 32'hFFFF_FFF8);

        // Restart: main instance from 0, wrap instance across 2^32
        @(negedge clock);
        reset            = 1'b0;
        bus0.instr_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("restart e%0d mem_sel", k), bus0.mem_sel, 32'(4 * k));
            check($sformatf("restart e%0d valid", k), {31'd0, bus0.instr_valid},
                  (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                check($sformatf("restart e%0d instr_pc", k), bus0.instr_pc, 32'(4 * (k - 2)));
                check($sformatf("wrap e%0d instr_pc", k), bus1.instr_pc,
                      32'hFFFF_FFF8 + 32'(4 * (k - 2)));
                check($sformatf("wrap e%0d instr_out", k), bus1.instr_out,
                      word_of(32'hFFFF_FFF8 + 32'(4 * (k - 2))));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch stage between instruction_memory and cpu_module.
- Generates sequential word fetch addresses on mem_sel and captures the returned words in a small FIFO.
- Presents instruction/PC pairs to the CPU with a valid/ready handshake.
- Supports redirect (branch/jump) with flush of all buffered and in-flight words.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch address loaded on reset (word aligned).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_sel  out  32  byte address to instruction_memory; combinationally equal to fetch_pc.
- mem_out  in  32  instruction word; valid one edge after its mem_sel was sampled.
- redirect  in  1  load new fetch address and flush.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- instr_out  out  32  head instruction word.
- instr_pc  out  32  byte address of head word.
- instr_valid  out  1  head entry valid (count != 0).
- instr_ready  in  1  consumer accepts head this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, any time, including mid-operation):
  - fetch_pc=RESET_PC, so mem_sel=RESET_PC.
  - count=0, in_flight=0, head/tail pointers 0.
  - instr_valid=0; instr_out=0, instr_pc=0 (all FIFO entries cleared).
- Memory timing: instruction_memory samples mem_sel at edge N and mem_out holds that word after edge N. A request issued at edge N is pushed into the FIFO at edge N+1.
- Issue condition at an edge: !redirect && (count + in_flight) < DEPTH.
  - On issue: in_flight<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - Address wrap: 32'hFFFF_FFFC + 4 = 0, mod 2^32, no flag.
  - No issue: fetch_pc holds; in_flight<=0 after any pending push.
- Push: at an edge where in_flight=1 and !redirect, write {mem_out, req_pc} at the tail; tail++ (mod DEPTH).
- Pop: instr_valid && instr_ready && !redirect; head++ (mod DEPTH).
- Count: count += push - pop. Simultaneous push and pop keeps count unchanged.
- Capacity: the issue rule guarantees push never occurs when full. Assertion required: no push with count==DEPTH.
- Throughput: with instr_ready held high, one instruction per cycle. First word is valid 2 edges after reset release.
- Redirect takes priority over issue, push and pop in the same cycle:
  - count<=0; head and tail pointers reset.
  - in_flight<=0; the outstanding response is discarded.
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - instr_valid is 0 after the edge.
  - First post-redirect word is valid 2 edges after the redirect edge.
- Back-to-back redirects: the last one wins; each restarts the 2-edge latency.
- instr_ready with instr_valid=0: ignored.
- instr_out and instr_pc are stable while instr_valid=1 and !instr_ready.
- Outputs are registered FIFO reads (no combinational path from instr_ready to instr_out). mem_sel depends only on fetch_pc.

Test Plan:
- Reset with RESET_PC=0, release, instr_ready=1 -> mem_sel 0,4,8,... one per cycle. instr_valid rises 2 edges after release with instr_pc=0, then 4, 8, 0xC on consecutive cycles; count never exceeds 1.
- Hold instr_ready=0 from release -> count reaches 4 with entries PC 0,4,8,0xC. mem_sel stalls at 0x10; no further pushes. Raise ready -> pops in order 0,4,8,0xC; fetching resumes at 0x10.
- Redirect to 0x103 while count=3 and a request is in flight -> next cycle instr_valid=0, count=0, mem_sel=0x100. Two edges later instr_pc=0x100; no stale word (old PCs) ever appears.
- Redirect asserted together with instr_ready=1 and a pending push -> redirect wins: no pop counted, no push, count=0.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0, 4.
- Assert reset asynchronously mid-burst (count=2, between clock edges) -> instr_valid, count and instr_out go to 0 immediately. mem_sel=RESET_PC. Normal restart after release.
